// File: rtl/ln_pkg.sv
// Shared constants and Q5.10 vector types for the LayerNorm output path.
// Elements are signed fixed point with FRAC_BITS fractional bits.
package ln_pkg;
  localparam int DATA_W    = 16;
  localparam int NUM_ELEM  = 16;
  localparam int FRAC_BITS = 10;

  typedef logic signed [DATA_W-1:0] q5_10_t;
  typedef q5_10_t [NUM_ELEM-1:0]    ln_vec_t;

  typedef enum logic {
    LN_EMPTY  = 1'b0,
    LN_STREAM = 1'b1
  } ln_state_t;
endpackage

// File: rtl/ln_vec_fifo.sv
// Whole-vector FIFO: a push writes all elements of a slot in one edge.
// Element reads are combinational from the head slot; a full FIFO accepts a push only alongside a pop.
module ln_vec_fifo #(
  parameter int  DEPTH    = 4,
  parameter int  DATA_W   = ln_pkg::DATA_W,
  parameter int  NUM_ELEM = ln_pkg::NUM_ELEM,
  localparam int PW       = $clog2(DEPTH),
  localparam int IW       = $clog2(NUM_ELEM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_push_req,
  input  logic [NUM_ELEM-1:0][DATA_W-1:0]  i_wr_vec,
  input  logic                             i_pop,
  input  logic [IW-1:0]                    i_rd_idx,
  output logic [DATA_W-1:0]                o_rd_elem,
  output logic [PW:0]                      o_count,
  output logic                             o_full,
  output logic                             o_push_acc,
  output logic                             o_drop
);

  logic [NUM_ELEM-1:0][DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]                   r_wr_ptr;
  logic [PW-1:0]                   r_rd_ptr;
  logic [PW:0]                     r_count;
  logic                            w_full;

  assign w_full     = (r_count == (PW+1)'(DEPTH));
  assign o_push_acc = i_push_req && (!w_full || i_pop);
  assign o_drop     = i_push_req && w_full && !i_pop;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_rd_elem  = r_mem[r_rd_ptr][i_rd_idx];

  // At full wr_ptr==rd_ptr, so this write lands in the slot whose last element
  // is being read combinationally in the same cycle; the NBA keeps that read intact.
  always_ff @(posedge clk) begin
    if (o_push_acc) r_mem[r_wr_ptr] <= i_wr_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({o_push_acc, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/layernorm_output_serializer.sv
// Buffers LayerNorm output vectors and replays them one element per accepted valid/ready transfer.
// First element is valid the cycle after a push into an empty FIFO; upstream cannot stall, so pushes at full without a pop are dropped and flagged.
module layernorm_output_serializer #(
  parameter int  DEPTH    = 4,
  parameter int  DATA_W   = ln_pkg::DATA_W,
  parameter int  NUM_ELEM = ln_pkg::NUM_ELEM,
  localparam int CW       = $clog2(DEPTH) + 1,
  localparam int IW       = $clog2(NUM_ELEM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vec_valid_in,
  input  logic signed [DATA_W-1:0] vec_in_0,
  input  logic signed [DATA_W-1:0] vec_in_1,
  input  logic signed [DATA_W-1:0] vec_in_2,
  input  logic signed [DATA_W-1:0] vec_in_3,
  input  logic signed [DATA_W-1:0] vec_in_4,
  input  logic signed [DATA_W-1:0] vec_in_5,
  input  logic signed [DATA_W-1:0] vec_in_6,
  input  logic signed [DATA_W-1:0] vec_in_7,
  input  logic signed [DATA_W-1:0] vec_in_8,
  input  logic signed [DATA_W-1:0] vec_in_9,
  input  logic signed [DATA_W-1:0] vec_in_10,
  input  logic signed [DATA_W-1:0] vec_in_11,
  input  logic signed [DATA_W-1:0] vec_in_12,
  input  logic signed [DATA_W-1:0] vec_in_13,
  input  logic signed [DATA_W-1:0] vec_in_14,
  input  logic signed [DATA_W-1:0] vec_in_15,
  output logic                     elem_valid,
  input  logic                     elem_ready,
  output logic signed [DATA_W-1:0] elem_data,
  output logic [IW-1:0]            elem_idx,
  output logic                     elem_last,
  output logic [CW-1:0]            fifo_count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  import ln_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEM - 1);

  ln_state_t                       r_state;
  logic [IW-1:0]                   r_idx;
  logic                            r_ovf;
  logic [NUM_ELEM-1:0][DATA_W-1:0] w_vec;
  logic [DATA_W-1:0]               w_rd_elem;
  logic [CW-1:0]                   w_count;
  logic                            w_full;
  logic                            w_push_acc;
  logic                            w_drop;
  logic                            w_xfer;
  logic                            w_pop;

  assign w_vec = {vec_in_15, vec_in_14, vec_in_13, vec_in_12,
                  vec_in_11, vec_in_10, vec_in_9,  vec_in_8,
                  vec_in_7,  vec_in_6,  vec_in_5,  vec_in_4,
                  vec_in_3,  vec_in_2,  vec_in_1,  vec_in_0};

  assign w_xfer = (r_state == LN_STREAM) && elem_ready;
  assign w_pop  = w_xfer && (r_idx == LAST_IDX);

  ln_vec_fifo #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .NUM_ELEM (NUM_ELEM)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_req (vec_valid_in),
    .i_wr_vec   (w_vec),
    .i_pop      (w_pop),
    .i_rd_idx   (r_idx),
    .o_rd_elem  (w_rd_elem),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_push_acc (w_push_acc),
    .o_drop     (w_drop)
  );

  // STREAM tracks count!=0 as a register so elem_valid has no path from vec_valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LN_EMPTY;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;

      if (w_xfer) r_idx <= w_pop ? '0 : r_idx + 1'b1;

      case (r_state)
        LN_EMPTY:  if (w_push_acc) r_state <= LN_STREAM;
        LN_STREAM: if (w_pop && !w_push_acc && (w_count == CW'(1))) r_state <= LN_EMPTY;
        default:   r_state <= LN_EMPTY;
      endcase
    end
  end

  assign elem_valid = (r_state == LN_STREAM);
  assign elem_data  = elem_valid ? w_rd_elem : '0;
  assign elem_idx   = r_idx;
  assign elem_last  = elem_valid && (r_idx == LAST_IDX);
  assign fifo_count = w_count;
  assign full       = w_full;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_layernorm_output_serializer.sv
// Scoreboard bench for layernorm_output_serializer: each driven vector queues its 16 expected elements.
module tb_layernorm_output_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_valid_in;
  logic        elem_ready;
  logic        clear_overflow;
  logic [15:0] vin [16];
  logic        elem_valid;
  logic [15:0] elem_data;
  logic [3:0]  elem_idx;
  logic        elem_last;
  logic [2:0]  fifo_count;
  logic        full;
  logic        overflow;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  idx;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  layernorm_output_serializer #(.DEPTH(4), .DATA_W(16), .NUM_ELEM(16)) dut (
    .clk(clk), .rst_n(rst_n), .vec_valid_in(vec_valid_in),
    .vec_in_0(vin[0]),   .vec_in_1(vin[1]),   .vec_in_2(vin[2]),   .vec_in_3(vin[3]),
    .vec_in_4(vin[4]),   .vec_in_5(vin[5]),   .vec_in_6(vin[6]),   .vec_in_7(vin[7]),
    .vec_in_8(vin[8]),   .vec_in_9(vin[9]),   .vec_in_10(vin[10]), .vec_in_11(vin[11]),
    .vec_in_12(vin[12]), .vec_in_13(vin[13]), .vec_in_14(vin[14]), .vec_in_15(vin[15]),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .elem_idx(elem_idx), .elem_last(elem_last), .fifo_count(fifo_count),
    .full(full), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  task automatic set_tag(input int tag);
    for (int i = 0; i < 16; i++) vin[i] = 16'(tag * 256 + i);
  endtask

  task automatic sb_add();
    exp_t x;
    for (int i = 0; i < 16; i++) begin
      x.d   = vin[i];
      x.idx = 4'(i);
      sb.push_back(x);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vec_valid_in = 1'b0; elem_ready = 1'b0; clear_overflow = 1'b0;
    set_tag(0);
    repeat (2) @(negedge clk);
    checks++; if (elem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", elem_valid); end
    checks++; if (elem_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", elem_data); end
    checks++; if (elem_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", elem_idx); end
    checks++; if (elem_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", elem_last); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int nx = 0;
    elem_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      vec_valid_in = (c == 0);
      if (c == 0) begin
        for (int i = 0; i < 16; i++) vin[i] = 16'(1024 * (i - 8));
        sb_add();
      end
      if (c == 1) begin
        checks++; if (elem_valid !== 1'b1) begin errors++; $display("FAIL single_latency: valid %b want 1", elem_valid); end
      end
      if (elem_valid && elem_ready) begin
        nx++; checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL single_extra: unexpected element %h idx %0d", elem_data, elem_idx); end
        else begin
          e = sb.pop_front();
          if (elem_data !== e.d || elem_idx !== e.idx || elem_last !== (e.idx == 4'd15)) begin
            errors++; $display("FAIL single_elem: got %h idx %0d last %b want %h idx %0d last %b",
                               elem_data, elem_idx, elem_last, e.d, e.idx, (e.idx == 4'd15));
          end
        end
      end
    end
    checks++; if (nx != 16) begin errors++; $display("FAIL single_count: %0d transfers want 16", nx); end
    checks++; if (elem_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL single_empty: valid %b count %0d want 0 0", elem_valid, fifo_count); end
  endtask

  task automatic test_backpressure();
    logic        held = 1'b0;
    logic [15:0] hd = '0;
    logic [3:0]  hi = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      vec_valid_in = (c == 0);
      if (c == 0) begin set_tag(8'h21); sb_add(); end
      elem_ready = (c % 4 == 0) || (c % 4 == 3);
      if (held) begin
        checks++;
        if (elem_valid !== 1'b1 || elem_data !== hd || elem_idx !== hi) begin
          errors++; $display("FAIL bp_stable: got v%b %h idx %0d want v1 %h idx %0d", elem_valid, elem_data, elem_idx, hd, hi);
        end
      end
      if (elem_valid && elem_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_extra: unexpected element %h idx %0d", elem_data, elem_idx); end
        else begin
          e = sb.pop_front();
          if (elem_data !== e.d || elem_idx !== e.idx || elem_last !== (e.idx == 4'd15)) begin
            errors++; $display("FAIL bp_elem: got %h idx %0d last %b want %h idx %0d", elem_data, elem_idx, elem_last, e.d, e.idx);
          end
        end
      end
      held = elem_valid && !elem_ready; hd = elem_data; hi = elem_idx;
    end
    checks++; if (sb.size() != 0 || elem_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: %0d left valid %b want 0 0", sb.size(), elem_valid); end
  endtask

  task automatic test_overflow();
    elem_ready = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      set_tag(t); vec_valid_in = 1'b1;
      if (t <= 4) sb_add();
    end
    @(negedge clk);
    vec_valid_in = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      elem_ready = 1'b1;
      if (elem_valid && elem_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL ovf_extra: unexpected element %h idx %0d", elem_data, elem_idx); end
        else begin
          e = sb.pop_front();
          if (elem_data !== e.d || elem_idx !== e.idx || elem_last !== (e.idx == 4'd15)) begin
            errors++; $display("FAIL ovf_elem: got %h idx %0d last %b want %h idx %0d", elem_data, elem_idx, elem_last, e.d, e.idx);
          end
        end
      end
      if (!elem_valid && sb.size() == 0) break;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ovf_drain: %0d elements left want 0", sb.size()); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic pushed = 1'b0;
    int   pc = -1;
    elem_ready = 1'b0;
    for (int t = 10; t <= 13; t++) begin
      @(negedge clk);
      set_tag(t); vec_valid_in = 1'b1; sb_add();
    end
    @(negedge clk);
    vec_valid_in = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full: got %b want 1", full); end
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      elem_ready = 1'b1; vec_valid_in = 1'b0;
      if (c == pc + 1 && pushed) begin
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          errors++; $display("FAIL fp_accept: count %0d ovf %b want 4 0", fifo_count, overflow);
        end
      end
      if (!pushed && elem_valid && elem_idx == 4'd15) begin
        set_tag(9); vec_valid_in = 1'b1; sb_add(); pushed = 1'b1; pc = c;
      end
      if (elem_valid && elem_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL fp_extra: unexpected element %h idx %0d", elem_data, elem_idx); end
        else begin
          e = sb.pop_front();
          if (elem_data !== e.d || elem_idx !== e.idx || elem_last !== (e.idx == 4'd15)) begin
            errors++; $display("FAIL fp_elem: got %h idx %0d last %b want %h idx %0d", elem_data, elem_idx, elem_last, e.d, e.idx);
          end
        end
      end
      if (!elem_valid && sb.size() == 0) break;
    end
    vec_valid_in = 1'b0;
    checks++; if (!pushed || sb.size() != 0 || overflow !== 1'b0) begin
      errors++; $display("FAIL fp_done: pushed %b left %0d ovf %b want 1 0 0", pushed, sb.size(), overflow);
    end
  endtask

  task automatic test_back_to_back();
    elem_ready = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      vec_valid_in = (c % 16 == 0) && (c < 64);
      if (vec_valid_in) begin set_tag(8'h40 + c / 16); sb_add(); end
      elem_ready = (c >= 2);
      if (c >= 1 && c <= 65) begin
        checks++;
        if (elem_valid !== 1'b1 || fifo_count < 3'd1 || fifo_count > 3'd2 || overflow !== 1'b0) begin
          errors++; $display("FAIL b2b_flow: cycle %0d valid %b count %0d ovf %b want 1 1..2 0", c, elem_valid, fifo_count, overflow);
        end
      end
      if (c == 17) begin
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_peak: count %0d want 2", fifo_count); end
      end
      if (elem_valid && elem_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_extra: unexpected element %h idx %0d", elem_data, elem_idx); end
        else begin
          e = sb.pop_front();
          if (elem_data !== e.d || elem_idx !== e.idx || elem_last !== (e.idx == 4'd15)) begin
            errors++; $display("FAIL b2b_elem: got %h idx %0d last %b want %h idx %0d", elem_data, elem_idx, elem_last, e.d, e.idx);
          end
        end
      end
      if (c > 65 && !elem_valid && sb.size() == 0) break;
    end
    vec_valid_in = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d elements left want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic hit = 1'b0;
    elem_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      set_tag(8'h51 + t); vec_valid_in = 1'b1; sb_add();
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      vec_valid_in = 1'b0; elem_ready = 1'b1;
      if (elem_valid && elem_idx == 4'd7) begin
        rst_n = 1'b0; elem_ready = 1'b0; hit = 1'b1;
        #1;
        checks++;
        if (elem_valid !== 1'b0 || elem_idx !== 4'd0 || elem_data !== 16'h0 || elem_last !== 1'b0 ||
            fifo_count !== 3'd0 || full !== 1'b0 || overflow !== 1'b0) begin
          errors++; $display("FAIL rm_reset: v%b idx %0d d %h last %b cnt %0d full %b ovf %b want all zero",
                             elem_valid, elem_idx, elem_data, elem_last, fifo_count, full, overflow);
        end
        break;
      end
      if (elem_valid && elem_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rm_extra: unexpected element %h idx %0d", elem_data, elem_idx); end
        else begin
          e = sb.pop_front();
          if (elem_data !== e.d || elem_idx !== e.idx) begin
            errors++; $display("FAIL rm_pre: got %h idx %0d want %h idx %0d", elem_data, elem_idx, e.d, e.idx);
          end
        end
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rm_hit: idx 7 never reached got 0 want 1"); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_tag(8'h77); vec_valid_in = 1'b1; sb_add();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      vec_valid_in = 1'b0; elem_ready = 1'b1;
      if (elem_valid && elem_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rm_extra2: unexpected element %h idx %0d", elem_data, elem_idx); end
        else begin
          e = sb.pop_front();
          if (elem_data !== e.d || elem_idx !== e.idx || elem_last !== (e.idx == 4'd15)) begin
            errors++; $display("FAIL rm_post: got %h idx %0d last %b want %h idx %0d", elem_data, elem_idx, elem_last, e.d, e.idx);
          end
        end
      end
      if (!elem_valid && sb.size() == 0) break;
    end
    checks++; if (sb.size() != 0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rm_drain: left %0d count %0d want 0 0", sb.size(), fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layernorm_output_serializer.md
Name: layernorm_output_serializer

Overview:
- Consumer-side endpoint for the 16-wide, valid-only (no backpressure) Q5.10 vector output of the LayerNorm pipeline.
- Captures each output vector in a small vector FIFO.
- Replays each stored vector as a stream of 16 elements over a valid/ready handshake, so downstream blocks can stall.
- The upstream pipeline cannot be stalled; overflow is detected, flagged sticky, and the offending vector is dropped.

Parameters:
- DEPTH, 4, number of vector slots; power of 2, minimum 2.
- DATA_W, 16, element width (Q5.10 signed).
- NUM_ELEM, 16, elements per vector; fixed, matches the pipeline vector width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- vec_valid_in  input  1  one-cycle strobe: vec_in_* holds a valid vector.
- vec_in_0 .. vec_in_15  input  DATA_W each  signed Q5.10 vector elements; index 0 is streamed first.
- elem_valid  output  1  elem_data holds a valid element.
- elem_ready  input  1  downstream accepts the element this cycle.
- elem_data  output  DATA_W  current element, signed Q5.10.
- elem_idx  output  4  index (0..15) of the current element within its vector.
- elem_last  output  1  high when elem_idx==15 and elem_valid.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied vector slots, including the slot being streamed.
- full  output  1  fifo_count==DEPTH.
- overflow  output  1  sticky: a vector was dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=rd_ptr=0, fifo_count=0, elem_idx=0, elem_valid=0, elem_last=0, full=0, overflow=0, elem_data=0. Slot contents need no reset.
- Transfer: occurs on a rising edge where elem_valid && elem_ready.
- Push: vec_valid_in && (!full || pop_this_cycle). All 16 elements are written to slot wr_ptr. wr_ptr increments modulo DEPTH.
- Pop: a transfer with elem_idx==15. rd_ptr increments modulo DEPTH; elem_idx returns to 0.
- Non-final transfer: elem_idx increments by 1.
- Simultaneous push and pop: fifo_count is unchanged. When full, the push is accepted because the popped slot frees in the same edge. Implementations must not write the slot being popped before its read completes; wr_ptr==rd_ptr at full guarantees the write lands in the slot being vacated.
- Drop: vec_valid_in && full && !pop_this_cycle. The vector is discarded; overflow is set at the next edge; pointers and count are unchanged.
- overflow: sticky until clear_overflow. If set and clear occur in the same cycle, set wins.
- Outputs:
  - elem_valid = (fifo_count != 0).
  - elem_data = slot[rd_ptr][elem_idx], driven from storage only.
  - No combinational path from vec_in_* or vec_valid_in to any output.
- Latency: a vector pushed at edge k gives elem_valid=1 after edge k (if the FIFO was empty). First transfer is possible at edge k+1. A vector is fully drained after 16 accepted transfers.
- Throughput: with elem_ready held high, 1 element per cycle. Sustained upstream rate must be ≤1 vector per 16 cycles, or overflow eventually occurs.
- elem_valid stays asserted while elem_ready is low. elem_data and elem_idx hold stable until transfer (AXI-stream rule).
- Arithmetic: data passes through bit-exact; no rounding or saturation.
- Control states: EMPTY (count==0) and STREAM (count>0). EMPTY→STREAM on push. STREAM→EMPTY on pop with count==1 and no push.
- Reset mid-stream discards all stored vectors and the partial element position. Streaming after reset restarts from a new vector at idx 0.

Decomposition:
- Shared package ln_pkg:
  - DATA_W and NUM_ELEM constants.
  - Q5.10 fraction-bits constant FRAC_BITS=10.
  - typedef q5_10_t (signed [15:0]).
  - typedef ln_vec_t (array of NUM_ELEM q5_10_t).
- Sub-module ln_vec_fifo: slot storage, pointers, count, full, write-through-at-full rule.
- Top level: element index counter, handshake, overflow flag.

Test Plan:
- Single vector: push vec_in_i = 16'h0400*(i-8) (wraps in 16 bits), elem_ready=1 → 16 consecutive transfers with elem_data=16'h0400*(idx-8) (same wrap), elem_idx 0..15, elem_last only at 15; then elem_valid=0 and fifo_count=0.
- Backpressure: push one vector, elem_ready toggles 1,0,0,1 repeatedly → no element skipped or duplicated; elem_data and elem_idx stable during ready=0.
- Overflow: elem_ready=0, push DEPTH+1 vectors with tags 1..5 → full=1, overflow=1, fifo_count=4; draining yields tags 1..4 in order. clear_overflow → overflow=0.
- Push at full with pop: FIFO full, push tag 9 in the cycle of the idx==15 transfer → accepted, overflow stays 0, tag 9 emerges last.
- Back-to-back pushes every 16 cycles, elem_ready=1 → continuous elem_valid with no bubble; fifo_count oscillates between 1 and 2 and never overflows.
- Reset mid-stream: assert rst_n=0 during idx 7 of 2 queued vectors → all outputs at reset values immediately; after release, a new push streams from idx 0 with the new data.
